bitwise_sliced_logic: RTL and testbench

BITWISE_SLICED_LOGIC -- requirements
Module: bitwise_sliced_logic

---
 rtl/bitwise_sliced_logic.sv | 118 +++++++++++
 tb/tb_bitwise_sliced_logic.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bitwise_sliced_logic.sv
// rtl/bitwise_sliced_logic.sv - slice-serial AND/OR/XOR/XNOR of two operands
// Processes SLICE bits per clock, LSB slice first; out/parity update only on completion.

module bitwise_sliced_logic #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             parity
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] result_full;
   logic [WIDTH-1:0] out_q;
   logic             parity_q;
   logic             busy_q;
   logic             done_q;

   always_comb begin
      result_full = '0;
      unique case (op_q)
         2'b00:   result_full = a_q & b_q;
         2'b01:   result_full = a_q | b_q;
         2'b10:   result_full = a_q ^ b_q;
         default: result_full = ~(a_q ^ b_q);
      endcase
   end

   // Only the slice selected by the counter is merged; constant indices keep it in range.
   always_comb begin
      acc_d = acc_q;
      for (int s = 0; s < N; s++) begin
         if (cnt_q == CW'(s)) begin
            acc_d[s*SLICE +: SLICE] = result_full[s*SLICE +: SLICE];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         out_q    <= '0;
         parity_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  op_q    <= op;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               if (cnt_q == LAST) begin
                  out_q    <= acc_d;
                  parity_q <= ^acc_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign out    = out_q;
   assign parity = parity_q;

endmodule

// File: tb/tb_bitwise_sliced_logic.sv
// tb/tb_bitwise_sliced_logic.sv - directed vector bench for bitwise_sliced_logic
// Instance u0 uses SLICE=8 (N=4); u1 uses SLICE=32 (N=1).

module tb_bitwise_sliced_logic;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy0, done0, parity0;
   logic [31:0] out0;
   logic        busy1, done1, parity1;
   logic [31:0] out1;

   int n_cmp;
   int n_err;
   logic [31:0] last_out;

   bitwise_sliced_logic #(.WIDTH(32), .SLICE(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
      .busy(busy0), .done(done0), .out(out0), .parity(parity0)
   );

   bitwise_sliced_logic #(.WIDTH(32), .SLICE(32)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
      .busy(busy1), .done(done1), .out(out1), .parity(parity1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        par;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      lat = 0;
      start = 1'b1; op = v.op; a = v.a; b = v.b;
      tick();
      start = 1'b0;
      chk("busy_after_accept", 32'(busy0), 32'd1);
      chk("out_hold_accept", out0, last_out);
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (done0) begin
            lat = c;
            break;
         end
         chk("out_hold_run", out0, last_out);
      end
      chk("latency", 32'(lat), 32'd4);
      chk("out", out0, v.exp);
      chk("parity", 32'(parity0), 32'(v.par));
      chk("busy_in_done", 32'(busy0), 32'd1);
      tick();
      chk("done_one_cycle", 32'(done0), 32'd0);
      chk("busy_idle", 32'(busy0), 32'd0);
      last_out = v.exp;
   endtask

   initial begin
      int busy_cnt, done_cnt, p0, p1, pulses;
      n_cmp = 0; n_err = 0; last_out = '0;

      vecs[0] = '{2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
      vecs[1] = '{2'b00, 32'hA5A5A5A5, 32'h0000FFFF, 32'h0000A5A5, 1'b0};
      vecs[2] = '{2'b01, 32'hA5A5A5A5, 32'h0000FFFF, 32'hA5A5FFFF, 1'b0};
      vecs[3] = '{2'b10, 32'hA5A5A5A5, 32'h0000FFFF, 32'hA5A55A5A, 1'b0};
      vecs[4] = '{2'b11, 32'hA5A5A5A5, 32'h0000FFFF, 32'h5A5AA5A5, 1'b0};
      vecs[5] = '{2'b10, 32'h00000001, 32'h00000000, 32'h00000001, 1'b1};
      vecs[6] = '{2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
      vecs[7] = '{2'b00, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b1};

      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      #2;
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_out", out0, 32'd0);
      chk("rst_parity", 32'(parity0), 32'd0);
      #10 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Re-pulsed start and operand changes while running must be ignored.
      start = 1'b1; op = 2'b10; a = 32'hFFFF0000; b = 32'h0F0F0F0F;
      tick();
      busy_cnt = busy0 ? 1 : 0;
      done_cnt = done0 ? 1 : 0;
      for (int j = 1; j < 10; j++) begin
         start = (j <= 3) ? 1'b1 : 1'b0;
         op = 2'b00; a = 32'h0000_0000 + j; b = 32'hFFFF_FFFF;
         if (j > 3) begin start = 1'b0; end
         tick();
         if (busy0) busy_cnt++;
         if (done0) begin
            done_cnt++;
            chk("rerun_out", out0, 32'hF0F00F0F);
         end
         start = 1'b0;
      end
      chk("rerun_busy_cycles", 32'(busy_cnt), 32'd5);
      chk("rerun_done_pulses", 32'(done_cnt), 32'd1);
      chk("rerun_out_final", out0, 32'hF0F00F0F);
      last_out = 32'hF0F00F0F;

      // Start held high: two operations, second with changed A.
      start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'h12345678;
      pulses = 0; p0 = -1; p1 = -1;
      for (int j = 0; j < 12; j++) begin
         tick();
         if (j == 1) a = 32'h0000FFFF;
         if (done0) begin
            if (pulses == 0) begin
               p0 = j;
               chk("held_out1", out0, 32'h12345678);
               last_out = 32'h12345678;
            end else begin
               p1 = j;
               chk("held_out2", out0, 32'h00005678);
               last_out = 32'h00005678;
            end
            pulses++;
         end else begin
            chk("held_out_stable", out0, last_out);
         end
      end
      start = 1'b0;
      chk("held_pulses", 32'(pulses), 32'd2);
      chk("held_gap", 32'(p1 - p0), 32'd6);

      // Asynchronous reset after two RUN cycles.
      start = 1'b1; op = 2'b01; a = 32'h0000FFFF; b = 32'hFF000000;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", 32'(busy0), 32'd0);
      chk("async_done", 32'(done0), 32'd0);
      chk("async_out", out0, 32'd0);
      chk("async_parity", 32'(parity0), 32'd0);
      #2 rst_n = 1'b1;
      last_out = '0;
      done_cnt = 0;
      for (int j = 0; j < 8; j++) begin
         tick();
         if (done0) done_cnt++;
         chk("post_rst_out", out0, 32'd0);
      end
      chk("post_rst_no_done", 32'(done_cnt), 32'd0);

      // Back-to-back: accept on the first edge after the reset period.
      run_vec(vecs[5]);

      // N=1 instance: XNOR of equal operands.
      start = 1'b1; op = 2'b11; a = 32'h12345678; b = 32'h12345678;
      tick();
      start = 1'b0;
      chk("n1_busy", 32'(busy1), 32'd1);
      chk("n1_done_early", 32'(done1), 32'd0);
      tick();
      chk("n1_done", 32'(done1), 32'd1);
      chk("n1_out", out1, 32'hFFFFFFFF);
      chk("n1_parity", 32'(parity1), 32'd0);
      tick();
      chk("n1_done_end", 32'(done1), 32'd0);
      chk("n1_busy_end", 32'(busy1), 32'd0);
      for (int j = 0; j < 6; j++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
